rom_port_arbiter: RTL and testbench

- Shares the single-port on-chip firmware ROM between two picorv32-style native memory requesters: port 0 is CPU fetch/load, port 1 is a debug/DMA reader.
- Sits between the SoC bus decode and the ROM array.
- Sequences each ROM read: grant, enable pulse, wait latency, capture, respond.
- Uses round-robin arbitration and rejects writes to read-only space.

---
 rtl/rom_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing the single-port firmware ROM between CPU (port 0) and debug/DMA (port 1).
// Defining ROM_ARB_STATS_EN adds saturating grant/conflict statistics outputs.
`timescale 1ns/1ps
module rom_port_arbiter #(
   parameter int ADDR_WIDTH  = 10,
   parameter int ROM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m0_valid,
   input  logic [31:0]           m0_addr,
   input  logic [3:0]            m0_wstrb,
   output logic                  m0_ready,
   output logic [31:0]           m0_rdata,
   input  logic                  m1_valid,
   input  logic [31:0]           m1_addr,
   input  logic [3:0]            m1_wstrb,
   output logic                  m1_ready,
   output logic [31:0]           m1_rdata,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]           rom_rdata,
   output logic                  wr_err
`ifdef ROM_ARB_STATS_EN
   ,
   output logic [15:0]           stat_grant0,
   output logic [15:0]           stat_grant1,
   output logic [15:0]           stat_conflict
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WERR, ST_RESP} state_t;

   localparam logic [2:0] LAT = 3'(ROM_LATENCY);

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic                  grant_q, grant_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  en_d, ready0_d, ready1_d, wr_err_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [31:0]           rdata0_d, rdata1_d;

   // Byte-lane and out-of-range address bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr[1:0], m0_addr[31:ADDR_WIDTH+2],
                               m1_addr[1:0], m1_addr[31:ADDR_WIDTH+2]};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      addr_d   = rom_addr;
      en_d     = 1'b0;
      ready0_d = 1'b0;
      ready1_d = 1'b0;
      rdata0_d = 32'h0;
      rdata1_d = 32'h0;
      wr_err_d = wr_err;
      unique case (state_q)
         ST_IDLE: begin
            if (m0_valid || m1_valid) begin
               grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
               last_d  = grant_d;
               if ((grant_d ? m1_wstrb : m0_wstrb) == 4'h0) begin
                  state_d = ST_READ;
                  en_d    = 1'b1;
                  cnt_d   = 3'd0;
                  addr_d  = grant_d ? m1_addr[ADDR_WIDTH+1:2] : m0_addr[ADDR_WIDTH+1:2];
               end else begin
                  state_d  = ST_WERR;
                  wr_err_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            // cnt_q counts cycles since the rom_en cycle; data is valid when it reaches LAT.
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAT) begin
               state_d  = ST_RESP;
               ready0_d = ~grant_q;
               ready1_d = grant_q;
               rdata0_d = grant_q ? 32'h0 : rom_rdata;
               rdata1_d = grant_q ? rom_rdata : 32'h0;
            end
         end
         ST_WERR: begin
            state_d  = ST_RESP;
            ready0_d = ~grant_q;
            ready1_d = grant_q;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         cnt_q    <= 3'd0;
         rom_en   <= 1'b0;
         rom_addr <= '0;
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         m0_rdata <= 32'h0;
         m1_rdata <= 32'h0;
         wr_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         rom_en   <= en_d;
         rom_addr <= addr_d;
         m0_ready <= ready0_d;
         m1_ready <= ready1_d;
         m0_rdata <= rdata0_d;
         m1_rdata <= rdata1_d;
         wr_err   <= wr_err_d;
      end
   end

`ifdef ROM_ARB_STATS_EN
   logic take, conflict;
   assign take     = (state_q == ST_IDLE) && (m0_valid || m1_valid);
   assign conflict = (state_q == ST_IDLE) && m0_valid && m1_valid;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_grant0   <= 16'h0;
         stat_grant1   <= 16'h0;
         stat_conflict <= 16'h0;
      end else begin
         if (take && !grant_d) stat_grant0 <= sat_inc(stat_grant0);
         if (take && grant_d)  stat_grant1 <= sat_inc(stat_grant1);
         if (conflict)         stat_conflict <= sat_inc(stat_conflict);
      end
   end
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: cycle-schedule reference model plus directed literal checks.
// A second instance with ROM_LATENCY=3 covers the longer read path.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

   localparam int AW  = 10;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          m0_valid, m1_valid, m0_ready, m1_ready, rom_en, wr_err;
   logic [31:0]   m0_addr, m1_addr, m0_rdata, m1_rdata, rom_rdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic [AW-1:0] rom_addr;

   logic          l_valid, l_ready, l1_ready, l_rom_en, l_wr_err;
   logic [31:0]   l_addr, l_rdata, l1_rdata, l_rom_rdata;
   logic [AW-1:0] l_rom_addr;
   logic [31:0]   l_pipe [3];

`ifdef ROM_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1, stat_conflict;
   logic [15:0] l_sg0, l_sg1, l_sc;
`endif

   logic [31:0] mem [0:1023];
   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM models: data appears LAT (resp. 3) cycles after the rom_en cycle, zero otherwise.
   always @(posedge clk) rom_rdata <= rom_en ? mem[rom_addr] : 32'h0;
   always @(posedge clk) begin
      l_pipe[0] <= l_rom_en ? mem[l_rom_addr] : 32'h0;
      l_pipe[1] <= l_pipe[0];
      l_pipe[2] <= l_pipe[1];
   end
   assign l_rom_rdata = l_pipe[2];

   rom_port_arbiter #(.ADDR_WIDTH(AW), .ROM_LATENCY(LAT)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .wr_err(wr_err)
`ifdef ROM_ARB_STATS_EN
      , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
   );

   rom_port_arbiter #(.ADDR_WIDTH(AW), .ROM_LATENCY(3)) u_lat (
      .clk(clk), .resetn(resetn),
      .m0_valid(l_valid), .m0_addr(l_addr), .m0_wstrb(4'h0),
      .m0_ready(l_ready), .m0_rdata(l_rdata),
      .m1_valid(1'b0), .m1_addr(32'h0), .m1_wstrb(4'h0),
      .m1_ready(l1_ready), .m1_rdata(l1_rdata),
      .rom_en(l_rom_en), .rom_addr(l_rom_addr), .rom_rdata(l_rom_rdata), .wr_err(l_wr_err)
`ifdef ROM_ARB_STATS_EN
      , .stat_grant0(l_sg0), .stat_grant1(l_sg1), .stat_conflict(l_sc)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: each grant schedules its outputs at absolute cycle numbers.
   logic [AW-1:0] exp_en [int];
   logic [31:0]   exp_r0 [int];
   logic [31:0]   exp_r1 [int];
   int            free_c = 0;
   int            werr_c = -1;
   logic          last_m = 1'b1;

   always @(negedge clk) begin
      int            c;
      logic          pick;
      logic [31:0]   a;
      logic [3:0]    ws;
      logic [AW-1:0] w;
      c = cyc;
      if (!resetn) begin
         check("rst rom_en", rom_en, 0);
         check("rst m0_ready", m0_ready, 0);
         check("rst m1_ready", m1_ready, 0);
         check("rst m0_rdata", m0_rdata, 0);
         check("rst wr_err", wr_err, 0);
         exp_en.delete();
         exp_r0.delete();
         exp_r1.delete();
         free_c = 0;
         werr_c = -1;
         last_m = 1'b1;
      end else begin
         check("model rom_en", rom_en, exp_en.exists(c) ? 1 : 0);
         if (exp_en.exists(c)) check("model rom_addr", rom_addr, exp_en[c]);
         check("model m0_ready", m0_ready, exp_r0.exists(c) ? 1 : 0);
         check("model m0_rdata", m0_rdata, exp_r0.exists(c) ? exp_r0[c] : 0);
         check("model m1_ready", m1_ready, exp_r1.exists(c) ? 1 : 0);
         check("model m1_rdata", m1_rdata, exp_r1.exists(c) ? exp_r1[c] : 0);
         check("model wr_err", wr_err, (werr_c >= 0 && c >= werr_c) ? 1 : 0);
         if (c >= free_c && (m0_valid || m1_valid)) begin
            pick   = (m0_valid && m1_valid) ? !last_m : m1_valid;
            last_m = pick;
            a      = pick ? m1_addr : m0_addr;
            ws     = pick ? m1_wstrb : m0_wstrb;
            w      = a[AW+1:2];
            if (ws == 4'h0) begin
               exp_en[c+1] = w;
               if (pick) exp_r1[c+2+LAT] = mem[w];
               else      exp_r0[c+2+LAT] = mem[w];
               free_c = c + 3 + LAT;
            end else begin
               if (pick) exp_r1[c+2] = 32'h0;
               else      exp_r0[c+2] = 32'h0;
               if (werr_c < 0) werr_c = c + 1;
               free_c = c + 3;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
      mem[0]    = 32'h0000_0013;
      mem[1]    = 32'h1234_5678;
      mem[2]    = 32'hCAFE_F00D;
      mem[5]    = 32'hDEAD_BEEF;
      mem[1023] = 32'h8000_0001;
      resetn = 1'b0;
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wstrb = 4'h0;
      l_valid  = 1'b0; l_addr  = 32'h0;
      step(2);
      check("reset rom_addr", rom_addr, 0);
      check("reset m1_rdata", m1_rdata, 0);
      check("reset lat ready", l_ready, 0);
      resetn = 1'b1;
      step(1);

      // Single read of word 5.
      m0_valid = 1'b1; m0_addr = 32'h14;
      step(1); check("t1 rom_en", rom_en, 1); check("t1 rom_addr", rom_addr, 5);
      step(1); check("t1 rom_en once", rom_en, 0); check("t1 early ready", m0_ready, 0);
      step(1); check("t1 m0_ready", m0_ready, 1); check("t1 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("t1 m1_ready", m1_ready, 0);
      m0_valid = 1'b0;
      step(1); check("t1 ready pulse", m0_ready, 0); check("t1 rdata cleared", m0_rdata, 0);

      // Write rejected on port 1.
      m1_valid = 1'b1; m1_addr = 32'h8; m1_wstrb = 4'hF;
      step(1); check("wr no rom_en", rom_en, 0); check("wr wr_err", wr_err, 1);
      step(1); check("wr m1_ready", m1_ready, 1); check("wr m1_rdata", m1_rdata, 0);
      check("wr m0_ready", m0_ready, 0);
      m1_valid = 1'b0; m1_wstrb = 4'h0;
      step(1);

      // Top word, byte-offset bits set.
      m0_valid = 1'b1; m0_addr = 32'h0000_0FFF;
      step(1); check("top rom_addr", rom_addr, 1023);
      step(2); check("top m0_rdata", m0_rdata, 32'h8000_0001); check("sticky wr_err", wr_err, 1);
      m0_valid = 1'b0;
      step(1);

      // Upper address bits ignored on port 1.
      m1_valid = 1'b1; m1_addr = 32'h8000_0017;
      step(3); check("hi m1_ready", m1_ready, 1); check("hi m1_rdata", m1_rdata, 32'hDEAD_BEEF);
      m1_valid = 1'b0;
      step(1);

      // Address changes and valid drops mid-transaction: latched address still served.
      m0_valid = 1'b1; m0_addr = 32'h4;
      step(1); m0_valid = 1'b0; m0_addr = 32'h8;
      step(2); check("viol m0_ready", m0_ready, 1); check("viol m0_rdata", m0_rdata, 32'h1234_5678);
      step(1);

      // Reset during READ, then contention from reset.
      m1_valid = 1'b1; m1_addr = 32'h8;
      step(1); check("rst rom_en before", rom_en, 1);
      #2 resetn = 1'b0;
      #1 check("rst async rom_en", rom_en, 0); check("rst async m1_ready", m1_ready, 0);
      step(1);
      m0_valid = 1'b1; m0_addr = 32'h0; m1_addr = 32'h4;
      resetn = 1'b1;
      for (int k = 1; k < 40; k++) begin
         step(1);
         check("rr m0_ready", m0_ready, (k % 8 == 3) ? 1 : 0);
         check("rr m1_ready", m1_ready, (k % 8 == 7) ? 1 : 0);
         if (k % 8 == 3) check("rr m0_rdata", m0_rdata, 32'h0000_0013);
         if (k % 8 == 7) check("rr m1_rdata", m1_rdata, 32'h1234_5678);
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
`ifdef ROM_ARB_STATS_EN
      check("stat_grant0", stat_grant0, 5);
      check("stat_grant1", stat_grant1, 5);
      check("stat_conflict ge 5", (stat_conflict >= 16'd5) ? 1 : 0, 1);
`endif
      step(1);

      // ROM_LATENCY=3 instance: ready in cycle 5.
      l_valid = 1'b1; l_addr = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("lat rom_en", l_rom_en, (k == 1) ? 1 : 0);
         check("lat ready", l_ready, (k == 5) ? 1 : 0);
         if (k == 5) begin
            check("lat rdata", l_rdata, 32'h0000_0013);
            l_valid = 1'b0;
         end
      end

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
